// File: rtl/cfeb_rdout_pkg.sv
// Shared types and constants for the CFEB readout sequencer.
package cfeb_rdout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_WAIT,
        ST_DATA,
        ST_TRL
    } state_t;

    localparam logic [3:0]  HDR_MARK = 4'hA;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int unsigned evt_words(input int unsigned nchan, input int unsigned nsamp);
        return 2 + nsamp * nchan + 1;
    endfunction

endpackage

// File: rtl/cfeb_rdout_chk.sv
// Word-wide event check accumulator: CRC-16-CCITT when CFEB_RDOUT_CRC16_EN is
// defined, otherwise a plain 16-bit XOR. i_clr restarts from the seed value.
module cfeb_rdout_chk
    import cfeb_rdout_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_word,
    output logic [15:0] o_value
);

`ifdef CFEB_RDOUT_CRC16_EN
    localparam logic [15:0] SEED = CRC_INIT;

    function automatic logic [15:0] step(input logic [15:0] acc, input logic [15:0] word);
        logic [15:0] c;
        c = acc ^ word;
        for (int b = 0; b < 16; b++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction
`else
    localparam logic [15:0] SEED = 16'h0000;

    function automatic logic [15:0] step(input logic [15:0] acc, input logic [15:0] word);
        return acc ^ word;
    endfunction
`endif

    logic [15:0] r_acc;
    logic [15:0] w_base;

    // Clearing and accumulating in the same cycle folds the first word onto the seed.
    assign w_base = i_clr ? SEED : r_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= SEED;
        end else if (i_en) begin
            r_acc <= step(w_base, i_word);
        end else if (i_clr) begin
            r_acc <= SEED;
        end
    end

    assign o_value = r_acc;

endmodule

// File: rtl/cfeb_rdout_seq.sv
// CFEB readout sequencer: header, NSAMP x NCHAN samples, check trailer, with a
// queue of pending L1A starts. Trailer type selected by CFEB_RDOUT_CRC16_EN.
module cfeb_rdout_seq
    import cfeb_rdout_pkg::*;
#(
    parameter int NCHAN = 6,
    parameter int ADC_W = 13,
    parameter int NSAMP = 8,
    parameter int L1A_W = 6,
    parameter int NPEND = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [L1A_W-1:0]       L1ANUM,
    input  logic [15:0]            STATUS,
    input  logic                   SMP_VLD,
    input  logic [NCHAN*ADC_W-1:0] ADC,
    output logic [15:0]            DOUT,
    output logic                   DVALID,
    output logic                   LASTWORD,
    output logic                   BUSY,
    output logic                   OVERLAP,
    output logic                   OVFL,
    output logic                   SMPERR
);

    localparam int CH_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int SM_W  = (NSAMP > 1) ? $clog2(NSAMP) : 1;
    localparam int CNT_W = $clog2(NPEND + 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NCHAN - 1);
    localparam logic [SM_W-1:0] LAST_SMP = SM_W'(NSAMP - 1);

    state_t                 r_state, w_state_nxt;
    logic [CH_W-1:0]        r_ch, w_ch_nxt;
    logic [SM_W-1:0]        r_smp_idx, w_smp_idx_nxt;
    logic [L1A_W-1:0]       r_l1a, w_l1a_nxt;
    logic [NCHAN*ADC_W-1:0] r_smp;
    logic [L1A_W-1:0]       r_q [NPEND];
    logic [CNT_W-1:0]       r_cnt;
    logic [15:0]            r_dout, w_dout_nxt;
    logic                   r_dvalid, w_dvalid_nxt;
    logic                   r_last, w_last_nxt;
    logic                   r_ovfl, r_smperr;
    logic                   w_busy, w_cap_win, w_cap, w_full, w_push, w_pop;
    logic                   w_chk_clr, w_chk_en;
    logic [CNT_W-1:0]       w_wr_idx;
    logic [15:0]            w_chk;

    function automatic logic [15:0] chan(input logic [NCHAN*ADC_W-1:0] bus, input int idx);
        return 16'(bus[idx*ADC_W +: ADC_W]);
    endfunction

    assign w_busy    = (r_state != ST_IDLE);
    assign w_cap_win = (r_state == ST_WAIT) ||
                       ((r_state == ST_DATA) && (r_ch == LAST_CH) && (r_smp_idx != LAST_SMP));
    assign w_cap     = SMP_VLD && w_cap_win;
    assign w_full    = (r_cnt == CNT_W'(NPEND));
    assign w_push    = START && w_busy && !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !START && (r_cnt != '0);
    assign w_wr_idx  = w_pop ? (r_cnt - CNT_W'(1)) : r_cnt;

    // NOTE: every always_comb output gets its default before the case, so no latch can form.
    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_smp_idx_nxt = r_smp_idx;
        w_l1a_nxt     = r_l1a;
        w_dout_nxt    = '0;
        w_dvalid_nxt  = 1'b0;
        w_last_nxt    = 1'b0;
        w_chk_clr     = 1'b0;
        w_chk_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START || (r_cnt != '0)) begin
                    w_l1a_nxt     = START ? L1ANUM : r_q[0];
                    w_state_nxt   = ST_HDR0;
                    w_ch_nxt      = '0;
                    w_smp_idx_nxt = '0;
                    w_dout_nxt    = {HDR_MARK, 12'(w_l1a_nxt)};
                    w_dvalid_nxt  = 1'b1;
                    w_chk_clr     = 1'b1;
                    w_chk_en      = 1'b1;
                end
            end
            ST_HDR0: begin
                w_state_nxt  = ST_HDR1;
                w_dout_nxt   = STATUS;
                w_dvalid_nxt = 1'b1;
                w_chk_en     = 1'b1;
            end
            ST_HDR1: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_cap) begin
                    w_state_nxt  = ST_DATA;
                    w_ch_nxt     = '0;
                    w_dout_nxt   = chan(ADC, 0);
                    w_dvalid_nxt = 1'b1;
                    w_chk_en     = 1'b1;
                end
            end
            ST_DATA: begin
                if (r_ch != LAST_CH) begin
                    w_ch_nxt     = r_ch + CH_W'(1);
                    w_dout_nxt   = chan(r_smp, int'(r_ch) + 1);
                    w_dvalid_nxt = 1'b1;
                    w_chk_en     = 1'b1;
                end else if (r_smp_idx != LAST_SMP) begin
                    w_smp_idx_nxt = r_smp_idx + SM_W'(1);
                    w_ch_nxt      = '0;
                    if (w_cap) begin
                        w_dout_nxt   = chan(ADC, 0);
                        w_dvalid_nxt = 1'b1;
                        w_chk_en     = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    // Accumulator already holds the last data word, loaded on entry to this cycle.
                    w_state_nxt  = ST_TRL;
                    w_dout_nxt   = w_chk;
                    w_dvalid_nxt = 1'b1;
                    w_last_nxt   = 1'b1;
                end
            end
            ST_TRL:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_smp_idx <= '0;
            r_l1a     <= '0;
            r_dout    <= '0;
            r_dvalid  <= 1'b0;
            r_last    <= 1'b0;
            r_ovfl    <= 1'b0;
            r_smperr  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_smp_idx <= w_smp_idx_nxt;
            r_l1a     <= w_l1a_nxt;
            r_dout    <= w_dout_nxt;
            r_dvalid  <= w_dvalid_nxt;
            r_last    <= w_last_nxt;
            if (START && w_busy && w_full) r_ovfl <= 1'b1;
            if (SMP_VLD && w_busy && !w_cap_win) r_smperr <= 1'b1;
        end
    end

    // NOTE: the sample register is pure datapath, only read after a capture, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (w_cap) r_smp <= ADC;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            for (int i = 0; i < NPEND; i++) r_q[i] <= '0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < NPEND - 1; i++) r_q[i] <= r_q[i+1];
            end
            if (w_push) r_q[w_wr_idx] <= L1ANUM;
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    cfeb_rdout_chk u_chk (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (w_chk_clr),
        .i_en    (w_chk_en),
        .i_word  (w_dout_nxt),
        .o_value (w_chk)
    );

    assign DOUT     = r_dout;
    assign DVALID   = r_dvalid;
    assign LASTWORD = r_last;
    assign BUSY     = w_busy;
    assign OVERLAP  = (r_cnt != '0);
    assign OVFL     = r_ovfl;
    assign SMPERR   = r_smperr;

endmodule

// File: tb/tb_cfeb_rdout_seq.sv
// Scoreboard bench for cfeb_rdout_seq: default instance plus two parameter-sweep instances.
module tb_cfeb_rdout_seq;

    localparam int NCHAN = 6;
    localparam int ADC_W = 13;
    localparam int NSAMP = 8;

    typedef struct {
        logic [15:0] word;
        logic        last;
        logic        hdr;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic                   start, smp_vld;
    logic [5:0]             l1anum;
    logic [15:0]            status;
    logic [NCHAN*ADC_W-1:0] adc;
    logic [15:0]            dout;
    logic                   dvalid, lastword, busy, overlap, ovfl, smperr;

    logic        s_start, s_smp;
    logic [5:0]  s_l1a;
    logic [15:0] s_status, s_dout;
    logic [14:0] s_adc;
    logic        s_dvalid, s_last, s_busy, s_overlap, s_ovfl, s_smperr;

    logic         b_start, b_smp;
    logic [5:0]   b_l1a;
    logic [15:0]  b_status, b_dout;
    logic [207:0] b_adc;
    logic         b_dvalid, b_last, b_busy, b_overlap, b_ovfl, b_smperr;

    cfeb_rdout_seq dut (
        .CLK(CLK), .RST(RST), .START(start), .L1ANUM(l1anum), .STATUS(status),
        .SMP_VLD(smp_vld), .ADC(adc), .DOUT(dout), .DVALID(dvalid), .LASTWORD(lastword),
        .BUSY(busy), .OVERLAP(overlap), .OVFL(ovfl), .SMPERR(smperr)
    );

    cfeb_rdout_seq #(.NCHAN(1), .ADC_W(15), .NSAMP(1)) u_small (
        .CLK(CLK), .RST(RST), .START(s_start), .L1ANUM(s_l1a), .STATUS(s_status),
        .SMP_VLD(s_smp), .ADC(s_adc), .DOUT(s_dout), .DVALID(s_dvalid), .LASTWORD(s_last),
        .BUSY(s_busy), .OVERLAP(s_overlap), .OVFL(s_ovfl), .SMPERR(s_smperr)
    );

    cfeb_rdout_seq #(.NCHAN(16), .NSAMP(32)) u_big (
        .CLK(CLK), .RST(RST), .START(b_start), .L1ANUM(b_l1a), .STATUS(b_status),
        .SMP_VLD(b_smp), .ADC(b_adc), .DOUT(b_dout), .DVALID(b_dvalid), .LASTWORD(b_last),
        .BUSY(b_busy), .OVERLAP(b_overlap), .OVFL(b_ovfl), .SMPERR(b_smperr)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          ev_started = 0;
    logic        hdr_ovl [32];
    exp_t        exp_q [$];
    logic [15:0] sm_words [$];
    int          sm_last_at = -1;
    int          bg_cnt = 0;
    int          bg_last_at = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference check: bit-serial CRC-16-CCITT, or XOR.
    function automatic logic [15:0] chk_init();
`ifdef CFEB_RDOUT_CRC16_EN
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [15:0] chk_step(input logic [15:0] acc, input logic [15:0] w);
`ifdef CFEB_RDOUT_CRC16_EN
        logic [15:0] c;
        logic        fb;
        c = acc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
`else
        return acc ^ w;
`endif
    endfunction

    function automatic logic [12:0] adc_val(input int seed, input int s, input int c);
        logic [31:0] h;
        if (seed < 0) return 13'h0;
        h = 32'(seed) * 32'h9E37 + 32'(s) * 32'h61 + 32'(c) * 32'h3B9 + 32'h55;
        return h[12:0] ^ h[25:13];
    endfunction

    function automatic logic [NCHAN*ADC_W-1:0] adc_bus(input int seed, input int s);
        logic [NCHAN*ADC_W-1:0] b;
        for (int c = 0; c < NCHAN; c++) b[c*ADC_W +: ADC_W] = adc_val(seed, s, c);
        return b;
    endfunction

    task automatic push_word(input logic [15:0] w, input logic last, input logic hdr);
        exp_t e;
        e.word = w;
        e.last = last;
        e.hdr  = hdr;
        exp_q.push_back(e);
    endtask

    task automatic push_event(input logic [5:0] l1a, input logic [15:0] st, input int seed);
        logic [15:0] acc;
        logic [15:0] w;
        acc = chk_init();
        w = {4'hA, 6'h00, l1a};
        push_word(w, 1'b0, 1'b1);
        acc = chk_step(acc, w);
        push_word(st, 1'b0, 1'b0);
        acc = chk_step(acc, st);
        for (int s = 0; s < NSAMP; s++) begin
            for (int c = 0; c < NCHAN; c++) begin
                w = {3'b000, adc_val(seed, s, c)};
                push_word(w, 1'b0, 1'b0);
                acc = chk_step(acc, w);
            end
        end
        push_word(acc, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic [5:0] l1a);
        start  = 1'b1;
        l1anum = l1a;
        tick();
        start  = 1'b0;
    endtask

    task automatic pulse_smp(input logic [NCHAN*ADC_W-1:0] bus);
        adc     = bus;
        smp_vld = 1'b1;
        tick();
        smp_vld = 1'b0;
    endtask

    task automatic wait_hdr(input int n);
        int k;
        k = 0;
        while (ev_started < n && k < 300) begin
            tick();
            k++;
        end
        check("hdr_seen", 32'(ev_started >= n), 32'd1);
    endtask

    task automatic drive_samples(input int seed, input int first);
        repeat (3) tick();
        for (int s = first; s < NSAMP; s++) begin
            pulse_smp(adc_bus(seed, s));
            repeat (9) tick();
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            tick();
            k++;
        end
        check("drain_q", 32'(exp_q.size()), 32'd0);
        check("idle", 32'(busy), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!RST && dvalid) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e.word));
                check("lastword", 32'(lastword), 32'(e.last));
                if (e.hdr) begin
                    hdr_ovl[ev_started % 32] = overlap;
                    ev_started++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && s_dvalid) begin
            sm_words.push_back(s_dout);
            if (s_last) sm_last_at = sm_words.size();
        end
        if (!RST && b_dvalid) begin
            bg_cnt++;
            if (b_last) bg_last_at = bg_cnt;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        logic [15:0] acc;
        RST = 1'b1;
        start = 1'b0; smp_vld = 1'b0; l1anum = '0; status = '0; adc = '0;
        s_start = 1'b0; s_smp = 1'b0; s_l1a = '0; s_status = '0; s_adc = '0;
        b_start = 1'b0; b_smp = 1'b0; b_l1a = '0; b_status = '0; b_adc = '0;
        repeat (3) tick();
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dvalid", 32'(dvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({lastword, overlap, ovfl, smperr}), 32'd0);
        RST = 1'b0;
        tick();

        // Single event, all-zero ADC and STATUS = 0.
        push_event(6'h15, 16'h0000, -1);
        pulse_start(6'h15);
        wait_hdr(1);
        drive_samples(-1, 0);
        wait_idle();

        // Single event with varied data and status.
        status = 16'h5A3C;
        push_event(6'h2A, 16'h5A3C, 1);
        pulse_start(6'h2A);
        wait_hdr(2);
        drive_samples(1, 0);
        wait_idle();
        check("no_smperr", 32'(smperr), 32'd0);
        check("no_ovfl", 32'(ovfl), 32'd0);

        // Back-to-back: four starts during one event, the last one dropped.
        status = 16'h1234;
        base = ev_started;
        for (int e = 0; e < 4; e++) push_event(6'(6'h10 + e), 16'h1234, 2 + e);
        pulse_start(6'h10);
        wait_hdr(base + 1);
        for (int e = 1; e <= 4; e++) pulse_start(6'(6'h10 + e));
        check("b2b_overlap", 32'(overlap), 32'd1);
        check("b2b_ovfl", 32'(ovfl), 32'd1);
        drive_samples(2, 0);
        for (int e = 1; e < 4; e++) begin
            wait_hdr(base + 1 + e);
            drive_samples(2 + e, 0);
        end
        wait_idle();
        check("ovl_ev0", 32'(hdr_ovl[base % 32]), 32'd0);
        check("ovl_ev1", 32'(hdr_ovl[(base + 1) % 32]), 32'd1);
        check("ovl_ev2", 32'(hdr_ovl[(base + 2) % 32]), 32'd1);
        check("ovl_ev3", 32'(hdr_ovl[(base + 3) % 32]), 32'd0);
        check("ovl_end", 32'(overlap), 32'd0);

        // Sample timing: last-channel capture, then a stray pulse mid-DATA.
        status = 16'h0F0F;
        base = ev_started;
        push_event(6'h20, 16'h0F0F, 7);
        pulse_start(6'h20);
        wait_hdr(base + 1);
        repeat (3) tick();
        pulse_smp(adc_bus(7, 0));
        repeat (5) tick();
        pulse_smp(adc_bus(7, 1));
        check("b2b_no_gap", 32'(dvalid), 32'd1);
        check("lastch_accept", 32'(smperr), 32'd0);
        repeat (9) tick();
        pulse_smp(adc_bus(7, 2));
        repeat (2) tick();
        pulse_smp(adc_bus(99, 0));
        check("smperr_set", 32'(smperr), 32'd1);
        repeat (6) tick();
        for (int s = 3; s < NSAMP; s++) begin
            pulse_smp(adc_bus(7, s));
            repeat (9) tick();
        end
        wait_idle();
        check("smperr_sticky", 32'(smperr), 32'd1);

        // Reset in the middle of sample 3, then a fresh event.
        status = 16'hC3C3;
        base = ev_started;
        push_event(6'h30, 16'hC3C3, 8);
        pulse_start(6'h30);
        wait_hdr(base + 1);
        repeat (3) tick();
        for (int s = 0; s < 4; s++) begin
            pulse_smp(adc_bus(8, s));
            if (s < 3) repeat (9) tick();
        end
        tick();
        RST = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_dvalid", 32'(dvalid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_flags", 32'({lastword, overlap, ovfl, smperr}), 32'd0);
        repeat (2) tick();
        RST = 1'b0;
        tick();
        push_event(6'h31, 16'hC3C3, 9);
        pulse_start(6'h31);
        wait_hdr(base + 2);
        drive_samples(9, 0);
        wait_idle();

        // Sweep: one channel, one sample, 15-bit ADC.
        s_status = 16'h8001;
        s_l1a    = 6'h07;
        s_start  = 1'b1;
        tick();
        s_start  = 1'b0;
        repeat (3) tick();
        s_adc = 15'h7FFF;
        s_smp = 1'b1;
        tick();
        s_smp = 1'b0;
        repeat (8) tick();
        check("small_words", 32'(sm_words.size()), 32'd4);
        check("small_last_at", 32'(sm_last_at), 32'd4);
        if (sm_words.size() >= 4) begin
            acc = chk_step(chk_step(chk_step(chk_init(), 16'hA007), 16'h8001), 16'h7FFF);
            check("small_hdr0", 32'(sm_words[0]), 32'h0000_A007);
            check("small_hdr1", 32'(sm_words[1]), 32'h0000_8001);
            check("small_adc", 32'(sm_words[2]), 32'h0000_7FFF);
            check("small_trl", 32'(sm_words[3]), 32'(acc));
        end
        check("small_flags", 32'({s_busy, s_overlap, s_ovfl, s_smperr}), 32'd0);

        // Sweep: 16 channels x 32 samples.
        b_status = 16'h4321;
        b_l1a    = 6'h3F;
        b_start  = 1'b1;
        tick();
        b_start  = 1'b0;
        repeat (3) tick();
        for (int s = 0; s < 32; s++) begin
            for (int k = 0; k < 16; k++) b_adc[k*13 +: 13] = 13'($urandom());
            b_smp = 1'b1;
            tick();
            b_smp = 1'b0;
            repeat (19) tick();
        end
        repeat (5) tick();
        check("big_words", 32'(bg_cnt), 32'd515);
        check("big_last_at", 32'(bg_last_at), 32'd515);
        check("big_flags", 32'({b_busy, b_overlap, b_ovfl, b_smperr}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
